core1588_sample_framer: RTL

CORE1588_SAMPLE_FRAMER -- requirements
Module: core1588_sample_framer

---
 rtl/core1588_sample_framer_if.sv | 16 +
 rtl/core1588_sample_framer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/core1588_sample_framer_if.sv
// ---------------------------------------------------------------------------
// core1588_sample_framer_if
// Sample stream handshake between a channel producer and the framer.
//   s_axis_tdata  : [23:16] channel ID, [15:0] sample
//   s_axis_tvalid : producer has a sample
//   s_axis_tready : framer accepts the sample this cycle
// Modports: master (producer side), slave (framer side).
// ---------------------------------------------------------------------------
interface core1588_sample_framer_if;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;

    modport master (output s_axis_tdata, output s_axis_tvalid, input s_axis_tready);
    modport slave  (input s_axis_tdata, input s_axis_tvalid, output s_axis_tready);
endinterface

// File: rtl/core1588_sample_framer.sv
// ---------------------------------------------------------------------------
// core1588_sample_framer
// Collects one sample per channel into a shadow set, timestamps the frame at
// channel 0, and on the last channel writes the frame (timestamp, samples,
// flags) into one half of a ping-pong BRAM, then pulses irq. A frame whose
// target half is still owned by software is dropped and counted.
// Optional feature: define FRAMER_CHKSUM_EN to append a mod-2^16 checksum
// halfword after the flags word.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis (slave)         sample stream
//   rtc_second/nanosecond  current RTC time
//   ext_trigger            asynchronous external trigger input
//   ctrl_trigger_*         trigger arm, source select and RTC compare time
//   irq_ack[1:0]           per-buffer release from software
//   bram_*                 halfword write port into the frame buffer
//   irq                    frame-ready pulse
//   status_buf             last completed buffer
//   status_drop_cnt        saturating dropped-frame count
// ---------------------------------------------------------------------------
module core1588_sample_framer #(
    parameter int NUM_CH  = 32,
    parameter int BRAM_AW = 12,
    parameter int IRQ_W   = 9
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    core1588_sample_framer_if.slave  s_axis,
    input  logic [31:0]              rtc_second,
    input  logic [31:0]              rtc_nanosecond,
    input  logic                     ext_trigger,
    input  logic                     ctrl_trigger_enable,
    input  logic [1:0]               ctrl_trigger_source,
    input  logic [31:0]              ctrl_trigger_second,
    input  logic [31:0]              ctrl_trigger_nanosecond,
    input  logic [1:0]               irq_ack,
    output logic                     bram_clk,
    output logic                     bram_rst,
    output logic [BRAM_AW-1:0]       bram_addr,
    output logic                     bram_en,
    output logic [1:0]               bram_we,
    output logic [15:0]              bram_din,
    output logic                     irq,
    output logic                     status_buf,
    output logic [15:0]              status_drop_cnt
);
    localparam int K_W  = BRAM_AW - 1;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef FRAMER_CHKSUM_EN
    localparam int FRAME_LEN = NUM_CH + 6;
`else
    localparam int FRAME_LEN = NUM_CH + 5;
`endif
    localparam logic [K_W-1:0] K_LAST  = K_W'(FRAME_LEN - 1);
    localparam logic [K_W-1:0] K_FLAGS = K_W'(NUM_CH + 4);
    localparam logic [7:0]     ID_LAST = 8'(NUM_CH - 1);

    typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wstate_t;
    typedef enum logic [1:0] {T_IDLE, T_ARMED, T_FIRED} tstate_t;

    wstate_t             wstate, wstate_nxt;
    tstate_t             tstate, tstate_nxt;
    logic [K_W-1:0]      k;
    logic                wr_buf;
    logic [1:0]          pending, pend_set;
    logic [NUM_CH-1:0]   valid_mask;
    logic [7:0]          seq;
    logic                drop_flag;
    logic [IRQ_W-1:0]    irq_cnt;
    logic                ready_en;
    logic                ext_sync_p0, ext_sync_p1, ext_sync_p2;
    logic [15:0]         shadow [NUM_CH];
    logic [31:0]         ts_sec, ts_ns;
    logic                triggered;
    logic [15:0]         hw_data, flags;
    logic [K_W-1:0]      sh_idx;
    logic [7:0]          id;
    logic                accept, id_ok, frame_done, last_hw, trig_evt, rtc_hit;
    logic                unused_bits;

    assign bram_clk = aclk;
    assign bram_rst = ~aresetn;

    assign id         = s_axis.s_axis_tdata[23:16];
    assign accept     = s_axis.s_axis_tvalid && s_axis.s_axis_tready;
    assign id_ok      = ({24'd0, id} < 32'(NUM_CH));
    assign frame_done = accept && (id == ID_LAST);
    assign last_hw    = (wstate == W_WRITE) && (k == K_LAST);
    // ready_en holds tready low until the first clock edge after reset release
    assign s_axis.s_axis_tready = ready_en && (wstate == W_IDLE);
    assign irq = (irq_cnt != '0);
    // Completion of buffer b marks it software-owned; set beats a same-cycle ack.
    assign pend_set = last_hw ? {wr_buf, ~wr_buf} : 2'b00;

    assign flags  = {seq, 5'b00000, drop_flag, ~&valid_mask, triggered};
    assign sh_idx = k - K_W'(4);
    assign unused_bits = ^{s_axis.s_axis_tdata[31:24], sh_idx[K_W-1:CH_W]};

    assign rtc_hit = (rtc_second == ctrl_trigger_second) &&
                     (rtc_nanosecond == ctrl_trigger_nanosecond);

    always_comb begin
        trig_evt = 1'b0;
        case (ctrl_trigger_source)
            2'b00:   trig_evt = ext_sync_p1 & ~ext_sync_p2;
            2'b01:   trig_evt = rtc_hit;
            default: trig_evt = 1'b0;
        endcase
    end

`ifdef FRAMER_CHKSUM_EN
    logic [15:0] csum;
    // Running sum of every halfword written so far in this frame.
    always_ff @(posedge aclk) begin
        if (wstate == W_WRITE)
            csum <= (k == '0) ? bram_din : csum + bram_din;
    end
`endif

    // Halfword selection by frame offset k
    always_comb begin
        hw_data = '0;
        if (k == K_W'(0))      hw_data = ts_sec[31:16];
        else if (k == K_W'(1)) hw_data = ts_sec[15:0];
        else if (k == K_W'(2)) hw_data = ts_ns[31:16];
        else if (k == K_W'(3)) hw_data = ts_ns[15:0];
        else if (k < K_FLAGS)  hw_data = shadow[sh_idx[CH_W-1:0]];
        else if (k == K_FLAGS) hw_data = flags;
`ifdef FRAMER_CHKSUM_EN
        else                   hw_data = csum;
`endif
    end

    // Writer FSM: next state and BRAM port
    always_comb begin
        wstate_nxt = wstate;
        bram_en    = 1'b0;
        bram_we    = 2'b00;
        bram_addr  = '0;
        bram_din   = '0;
        case (wstate)
            W_IDLE:  if (frame_done) wstate_nxt = pending[wr_buf] ? W_DROP : W_WRITE;
            W_WRITE: begin
                bram_en   = 1'b1;
                bram_we   = 2'b11;
                bram_addr = {wr_buf, k};
                bram_din  = hw_data;
                if (k == K_LAST) wstate_nxt = W_IDLE;
            end
            W_DROP:  wstate_nxt = W_IDLE;
            default: wstate_nxt = W_IDLE;
        endcase
    end

    // Trigger FSM: next state
    always_comb begin
        tstate_nxt = tstate;
        if (!ctrl_trigger_enable) begin
            tstate_nxt = T_IDLE;
        end else begin
            case (tstate)
                T_IDLE:  tstate_nxt = T_ARMED;
                T_ARMED: if (trig_evt) tstate_nxt = T_FIRED;
                T_FIRED: if (accept && id == 8'd0) tstate_nxt = T_IDLE;
                default: tstate_nxt = T_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wstate <= W_IDLE;
            tstate <= T_IDLE;
        end else begin
            wstate <= wstate_nxt;
            tstate <= tstate_nxt;
        end
    end

    // Control state
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            k               <= '0;
            wr_buf          <= 1'b0;
            pending         <= 2'b00;
            valid_mask      <= '0;
            seq             <= '0;
            drop_flag       <= 1'b0;
            status_drop_cnt <= '0;
            status_buf      <= 1'b0;
            irq_cnt         <= '0;
            ready_en        <= 1'b0;
            ext_sync_p0     <= 1'b0;
            ext_sync_p1     <= 1'b0;
            ext_sync_p2     <= 1'b0;
        end else begin
            ready_en    <= 1'b1;
            ext_sync_p0 <= ext_trigger;
            ext_sync_p1 <= ext_sync_p0;
            ext_sync_p2 <= ext_sync_p1;
            pending     <= (pending & ~irq_ack) | pend_set;
            if (accept && id_ok) valid_mask[id[CH_W-1:0]] <= 1'b1;
            if (irq_cnt != '0) irq_cnt <= irq_cnt - 1'b1;
            case (wstate)
                W_WRITE: begin
                    if (k == K_LAST) begin
                        k          <= '0;
                        status_buf <= wr_buf;
                        wr_buf     <= ~wr_buf;
                        valid_mask <= '0;
                        seq        <= seq + 8'd1;
                        drop_flag  <= 1'b0;
                        irq_cnt    <= '1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                W_DROP: begin
                    if (status_drop_cnt != 16'hFFFF) status_drop_cnt <= status_drop_cnt + 16'd1;
                    drop_flag  <= 1'b1;
                    valid_mask <= '0;
                end
                default: ;
            endcase
        end
    end

    // Frame data: shadow samples, timestamp and trigger flag survive reset
    always_ff @(posedge aclk) begin
        if (accept && id_ok) shadow[id[CH_W-1:0]] <= s_axis.s_axis_tdata[15:0];
        if (accept && id == 8'd0) begin
            ts_sec    <= rtc_second;
            ts_ns     <= rtc_nanosecond;
            triggered <= (tstate == T_FIRED);
        end
    end
endmodule
